regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 18 +
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 67 ++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults, the zero-register constant and read-port slicing helpers for regfile_mp.
// The macros expect ADDR_W / DATA_W to be in scope where they are expanded.
`ifndef REGFILE_MP_PKG_SV
`define REGFILE_MP_PKG_SV

`define RF_ADDR_SLICE(vec, k) vec[(k)*ADDR_W +: ADDR_W]
`define RF_DATA_SLICE(vec, k) vec[(k)*DATA_W +: DATA_W]

package regfile_mp_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;
    localparam int unsigned DefNumRd = 2;
    localparam int unsigned ZeroReg  = 0;

endpackage

`endif

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_RD = DefNumRd
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_clr;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, wb_clr,
               rsv_en, rsv_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data, busy_cnt
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, wb_clr,
               rsv_en, rsv_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, clear at load writeback, running busy count.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_RD = DefNumRd,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    logic [Depth-1:0] busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             set, clr, same, inc, dec;

    assign set  = rsv_en && (rsv_addr != ADDR_W'(ZeroReg));
    assign clr  = clr_en && (clr_addr != ADDR_W'(ZeroReg));
    assign same = set && clr && (rsv_addr == clr_addr);
    assign inc  = set && !busy_q[rsv_addr];
    // A same-address set/clear keeps the bit set, so the clear never counts there.
    assign dec  = clr && busy_q[clr_addr] && !same;

    always_comb begin
        busy_d = busy_q;
        if (clr) busy_d[clr_addr] = 1'b0;
        if (set) busy_d[rsv_addr] = 1'b1;
        cnt_d = cnt_q + CntW'(inc) - CntW'(dec);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              fwd_clr;
        assign a       = `RF_ADDR_SLICE(rd_addr, k);
        assign fwd_clr = (BYPASS != 0) && clr && (clr_addr == a) && !(set && (rsv_addr == a));
        assign rd_busy[k] = busy_q[a] && !fwd_clr;
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with optional write-to-read bypass and busy scoreboard.
// Write port A (ALU) wins over port B (load) on an address collision.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_RD = DefNumRd,
    parameter int unsigned BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] Zero = ADDR_W'(ZeroReg);

    logic [DATA_W-1:0] mem_q [Depth];
    logic              wa_hit, wb_hit;

    assign wa_hit = bus.wa_en && (bus.wa_addr != Zero);
    assign wb_hit = bus.wb_en && (bus.wb_addr != Zero) && !(wa_hit && (bus.wa_addr == bus.wb_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            if (wa_hit) mem_q[bus.wa_addr] <= bus.wa_data;
            if (wb_hit) mem_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        assign a = `RF_ADDR_SLICE(bus.rd_addr, k);
        always_comb begin
            d = mem_q[a];
            if (a == Zero) begin
                d = '0;
            end else if ((BYPASS != 0) && wa_hit && (bus.wa_addr == a)) begin
                d = bus.wa_data;
            end else if ((BYPASS != 0) && bus.wb_en && (bus.wb_addr == a)) begin
                d = bus.wb_data;
            end
        end
        assign `RF_DATA_SLICE(bus.rd_data, k) = d;
    end

    assign bus.dbg_data = (bus.dbg_addr == Zero) ? '0 : mem_q[bus.dbg_addr];

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (bus.rd_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .clr_en   (bus.wb_en && bus.wb_clr),
        .clr_addr (bus.wb_addr),
        .rd_busy  (bus.rd_busy),
        .busy_cnt (bus.busy_cnt)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one BYPASS=1 and one BYPASS=0 instance driven by shared directed stimulus,
// checked every cycle against an array model plus hand-computed literal expectations.
module tb_regfile_mp;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] rd_addr = '0;
    logic             wa_en = 0, wb_en = 0, wb_clr = 0, rsv_en = 0;
    logic [AW-1:0]    wa_addr = '0, wb_addr = '0, rsv_addr = '0, dbg_addr = '0;
    logic [DW-1:0]    wa_data = '0, wb_data = '0;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if1 ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if0 ();

    assign if1.rd_addr = rd_addr;   assign if0.rd_addr = rd_addr;
    assign if1.wa_en = wa_en;       assign if0.wa_en = wa_en;
    assign if1.wa_addr = wa_addr;   assign if0.wa_addr = wa_addr;
    assign if1.wa_data = wa_data;   assign if0.wa_data = wa_data;
    assign if1.wb_en = wb_en;       assign if0.wb_en = wb_en;
    assign if1.wb_addr = wb_addr;   assign if0.wb_addr = wb_addr;
    assign if1.wb_data = wb_data;   assign if0.wb_data = wb_data;
    assign if1.wb_clr = wb_clr;     assign if0.wb_clr = wb_clr;
    assign if1.rsv_en = rsv_en;     assign if0.rsv_en = rsv_en;
    assign if1.rsv_addr = rsv_addr; assign if0.rsv_addr = rsv_addr;
    assign if1.dbg_addr = dbg_addr; assign if0.dbg_addr = dbg_addr;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut1 (
        .clk (clk), .reset (reset), .bus (if1.slave)
    );
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut0 (
        .clk (clk), .reset (reset), .bus (if0.slave)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: stored registers and busy bits.
    logic [DW-1:0] m_reg [32];
    logic          m_busy [32];
    initial for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_reg[i] <= '0; m_busy[i] <= 1'b0; end
        end else begin
            if (wb_en && wb_addr != 0 && !(wa_en && wa_addr == wb_addr)) m_reg[wb_addr] <= wb_data;
            if (wa_en && wa_addr != 0) m_reg[wa_addr] <= wa_data;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
            else if (wb_en && wb_clr && wb_addr != 0) m_busy[wb_addr] <= 1'b0;
            if (rsv_en && rsv_addr != 0 && wb_en && wb_clr && wb_addr != 0 && wb_addr != rsv_addr)
                m_busy[wb_addr] <= 1'b0;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp && wa_en && wa_addr == a) return wa_data;
        if (byp && wb_en && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
        if (byp && wb_en && wb_clr && wb_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [AW:0] exp_cnt();
        logic [AW:0] c = '0;
        for (int i = 0; i < 32; i++) c += {5'd0, m_busy[i]};
        return c;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            chk($sformatf("b1 rd_data%0d", k), 64'(if1.rd_data[k*DW +: DW]), 64'(exp_rd(1, a)));
            chk($sformatf("b0 rd_data%0d", k), 64'(if0.rd_data[k*DW +: DW]), 64'(exp_rd(0, a)));
            chk($sformatf("b1 rd_busy%0d", k), 64'(if1.rd_busy[k]), 64'(exp_busy(1, a)));
            chk($sformatf("b0 rd_busy%0d", k), 64'(if0.rd_busy[k]), 64'(exp_busy(0, a)));
        end
        chk("b1 dbg_data", 64'(if1.dbg_data), 64'(exp_rd(0, dbg_addr)));
        chk("b0 dbg_data", 64'(if0.dbg_data), 64'(exp_rd(0, dbg_addr)));
        chk("b1 busy_cnt", 64'(if1.busy_cnt), 64'(exp_cnt()));
        chk("b0 busy_cnt", 64'(if0.busy_cnt), 64'(exp_cnt()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; wb_clr = 0; rsv_en = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Fill every register and reserve all of them: count reaches its maximum.
        for (int i = 1; i < 32; i++) begin
            wa_en = 1; wa_addr = AW'(i); wa_data = 32'h100 + i;
            rsv_en = 1; rsv_addr = AW'(i);
            tick();
        end
        idle(); dbg_addr = 5'd31;
        @(negedge clk);
        chk("full busy_cnt", 64'(if1.busy_cnt), 64'd31);
        chk("fill dbg r31", 64'(if1.dbg_data), 64'h11f);

        // Reset two cycles with everything populated.
        tick(); reset = 1; tick(); tick(); reset = 0;
        rd_addr = {5'd31, 5'd17}; dbg_addr = 5'd12;
        @(negedge clk);
        chk("rst rd_data", 64'(if1.rd_data), 64'd0);
        chk("rst dbg", 64'(if0.dbg_data), 64'd0);
        chk("rst rd_busy", 64'(if1.rd_busy), 64'd0);
        chk("rst busy_cnt", 64'(if0.busy_cnt), 64'd0);

        // Same-cycle bypass vs stored-only read.
        tick(); rd_addr = {5'd0, 5'd5};
        wa_en = 1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("byp1 same cycle", 64'(if1.rd_data[31:0]), 64'hDEADBEEF);
        chk("byp0 same cycle", 64'(if0.rd_data[31:0]), 64'd0);
        tick(); idle();
        @(negedge clk);
        chk("byp0 next cycle", 64'(if0.rd_data[31:0]), 64'hDEADBEEF);

        // Register 0 ignores writes and reserves.
        tick(); rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        wa_en = 1; wa_addr = 5'd0; wa_data = 32'h12345678; rsv_en = 1; rsv_addr = 5'd0;
        @(negedge clk);
        chk("r0 bypass", 64'(if1.rd_data), 64'd0);
        tick(); idle();
        @(negedge clk);
        chk("r0 busy_cnt", 64'(if1.busy_cnt), 64'd0);
        chk("r0 dbg", 64'(if1.dbg_data), 64'd0);

        // Write-port collision: A wins.
        tick(); rd_addr = {5'd7, 5'd5};
        wa_en = 1; wa_addr = 5'd7; wa_data = 32'h1; wb_en = 1; wb_addr = 5'd7; wb_data = 32'h2;
        @(negedge clk);
        chk("collide byp", 64'(if1.rd_data[63:32]), 64'h1);
        tick(); idle();
        @(negedge clk);
        chk("collide b1", 64'(if1.rd_data[63:32]), 64'h1);
        chk("collide b0", 64'(if0.rd_data[63:32]), 64'h1);

        // Scoreboard sequence on r9.
        tick(); rd_addr = {5'd5, 5'd9}; rsv_en = 1; rsv_addr = 5'd9;
        tick(); idle();
        @(negedge clk);
        chk("rsv9 cnt", 64'(if1.busy_cnt), 64'd1);
        chk("rsv9 busy", 64'(if1.rd_busy[0]), 64'd1);
        tick(); rsv_en = 1; rsv_addr = 5'd9;
        tick(); idle();
        @(negedge clk);
        chk("rsv9 again cnt", 64'(if1.busy_cnt), 64'd1);
        tick(); wb_en = 1; wb_clr = 1; wb_addr = 5'd9; wb_data = 32'hAA;
        @(negedge clk);
        chk("clr9 byp busy", 64'(if1.rd_busy[0]), 64'd0);
        chk("clr9 nobyp busy", 64'(if0.rd_busy[0]), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("clr9 cnt", 64'(if1.busy_cnt), 64'd0);
        chk("clr9 data", 64'(if0.rd_data[31:0]), 64'hAA);
        tick(); rsv_en = 1; rsv_addr = 5'd9; wb_en = 1; wb_clr = 1; wb_addr = 5'd9;
        tick(); idle();
        @(negedge clk);
        chk("set+clr cnt", 64'(if1.busy_cnt), 64'd1);
        chk("set+clr busy", 64'(if1.rd_busy[0]), 64'd1);
        tick(); rsv_en = 1; rsv_addr = 5'd9; wb_en = 1; wb_clr = 1; wb_addr = 5'd9;
        @(negedge clk);
        chk("set+clr busy byp", 64'(if1.rd_busy[0]), 64'd1);
        tick(); idle();

        // Asynchronous reset between edges.
        rsv_en = 1; rsv_addr = 5'd3;
        tick(); idle(); rd_addr = {5'd3, 5'd9};
        @(negedge clk);
        chk("pre-rst cnt", 64'(if1.busy_cnt), 64'd2);
        chk("pre-rst busy", 64'(if1.rd_busy), 64'd3);
        #2 reset = 1;
        #1;
        chk("async cnt b1", 64'(if1.busy_cnt), 64'd0);
        chk("async cnt b0", 64'(if0.busy_cnt), 64'd0);
        chk("async busy b1", 64'(if1.rd_busy), 64'd0);
        chk("async busy b0", 64'(if0.rd_busy), 64'd0);
        #1 reset = 0;
        tick();
        @(negedge clk);
        chk("post-rst cnt", 64'(if1.busy_cnt), 64'd0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
